// File: rtl/sync_short_pkg.sv
// Shared types and constants for the short-preamble sync chain.
// State encoding, Q3 scaling shift and default plateau settings.
package sync_short_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FILL    = 3'd1,
      SEARCH  = 3'd2,
      LOCKED  = 3'd3,
      HOLDOFF = 3'd4
   } state_t;

   // corr_mag is compared in Q3 against pwr*THRESH
   localparam int Q3_SHIFT        = 3;
   localparam int THRESH_DEF      = 6;
   localparam int PLATEAU_MIN_DEF = 48;
   localparam int PWR_MIN_DEF     = 100;

endpackage

// File: rtl/sync_plateau_cnt.sv
// Plateau detector: Q3 threshold compare, power floor, run counter.
// Ports: CLK, s_RST, strobe, clear, corr_mag, pwr -> hit, plateau_reached.
module sync_plateau_cnt
   import sync_short_pkg::*;
#(
   parameter int MAG_W       = 32,
   parameter int THRESH      = THRESH_DEF,
   parameter int PLATEAU_MIN = PLATEAU_MIN_DEF,
   parameter int PWR_MIN     = PWR_MIN_DEF
) (
   input  logic             CLK,
   input  logic             s_RST,
   input  logic             strobe,
   input  logic             clear,
   input  logic [MAG_W-1:0] corr_mag,
   input  logic [MAG_W-1:0] pwr,
   output logic             hit,
   output logic             plateau_reached
);

   localparam int CW = MAG_W + 8;

   logic [CW-1:0] lhs;
   logic [CW-1:0] rhs;
   logic [15:0]   plat_cnt;

   // widened before scaling so neither side can overflow
   assign lhs = CW'(corr_mag) << Q3_SHIFT;
   assign rhs = CW'(pwr) * CW'(THRESH);

   assign hit = (pwr >= MAG_W'(PWR_MIN)) && (lhs >= rhs);

   // fires on the hit strobe that completes the run
   assign plateau_reached = strobe && hit &&
      (({1'b0, plat_cnt} + 17'd1) == 17'(PLATEAU_MIN));

   always_ff @(posedge CLK) begin
      if (s_RST || clear) begin
         plat_cnt <= '0;
      end else if (strobe) begin
         if (!hit)
            plat_cnt <= '0;
         else if (plat_cnt != 16'hFFFF)
            plat_cnt <= plat_cnt + 16'd1;
      end
   end

endmodule

// File: rtl/sync_short_ctrl.sv
// Short-preamble sync sequencer: fill wait, plateau search, lock/timeout.
// Ports: CLK, s_RST, start, abort, sample_strobe, corr_mag, pwr ->
//   dly_enable, search_active, detect, detect_idx, timeout, state.
module sync_short_ctrl
   import sync_short_pkg::*;
#(
   parameter int DELAY_LEN       = 16,
   parameter int MAG_W           = 32,
   parameter int THRESH          = THRESH_DEF,
   parameter int PLATEAU_MIN     = PLATEAU_MIN_DEF,
   parameter int PWR_MIN         = PWR_MIN_DEF,
   parameter int TIMEOUT_SAMPLES = 4000,
   parameter int HOLDOFF_CYC     = 4,
   parameter int AUTO_RESTART    = 0
) (
   input  logic             CLK,
   input  logic             s_RST,
   input  logic             start,
   input  logic             abort,
   input  logic             sample_strobe,
   input  logic [MAG_W-1:0] corr_mag,
   input  logic [MAG_W-1:0] pwr,
   output logic             dly_enable,
   output logic             search_active,
   output logic             detect,
   output logic [15:0]      detect_idx,
   output logic             timeout,
   output logic [2:0]       state
);

   state_t      st;
   state_t      st_d;
   logic [15:0] fill_cnt;
   logic [15:0] sample_cnt;
   logic [7:0]  hold_cnt;

   logic        dly_d;
   logic        srch_d;
   logic        det_d;
   logic        to_d;
   logic [15:0] idx_d;

   logic        strb_srch;
   logic        hit;
   logic        plat_hit;
   logic        det_ev;
   logic        to_ev;
   logic        fill_done;
   logic        hold_done;
   logic        start_ok;

   assign strb_srch = sample_strobe && (st == SEARCH);
   assign det_ev    = strb_srch && hit && plat_hit;
   // detection outranks timeout on the same strobe
   assign to_ev     = strb_srch && !det_ev &&
      (({1'b0, sample_cnt} + 17'd1) == 17'(TIMEOUT_SAMPLES));
   assign fill_done = sample_strobe && (st == FILL) &&
      (({1'b0, fill_cnt} + 17'd1) == 17'(DELAY_LEN));
   assign hold_done = (st == HOLDOFF) &&
      (hold_cnt == 8'(HOLDOFF_CYC - 1));
   assign start_ok  = (st == IDLE) && start;

   sync_plateau_cnt #(
      .MAG_W       (MAG_W),
      .THRESH      (THRESH),
      .PLATEAU_MIN (PLATEAU_MIN),
      .PWR_MIN     (PWR_MIN)
   ) u_plat (
      .CLK             (CLK),
      .s_RST           (s_RST),
      .strobe          (strb_srch),
      .clear           (st != SEARCH),
      .corr_mag        (corr_mag),
      .pwr             (pwr),
      .hit             (hit),
      .plateau_reached (plat_hit)
   );

   // state register, counters and registered outputs
   always_ff @(posedge CLK) begin
      if (s_RST) begin
         st            <= IDLE;
         fill_cnt      <= '0;
         sample_cnt    <= '0;
         hold_cnt      <= '0;
         dly_enable    <= 1'b0;
         search_active <= 1'b0;
         detect        <= 1'b0;
         timeout       <= 1'b0;
         detect_idx    <= '0;
      end else begin
         st            <= st_d;
         dly_enable    <= dly_d;
         search_active <= srch_d;
         detect        <= det_d;
         timeout       <= to_d;
         detect_idx    <= idx_d;

         if (st != FILL)
            fill_cnt <= '0;
         else if (sample_strobe)
            fill_cnt <= fill_cnt + 16'd1;

         if ((st == IDLE) || (st == HOLDOFF))
            sample_cnt <= '0;
         else if (strb_srch && (sample_cnt != 16'hFFFF))
            sample_cnt <= sample_cnt + 16'd1;

         if (st == HOLDOFF)
            hold_cnt <= hold_cnt + 8'd1;
         else
            hold_cnt <= '0;
      end
   end

   // next state
   always_comb begin
      st_d = st;
      unique case (st)
         IDLE: begin
            if (start)
               st_d = FILL;
         end
         FILL: begin
            if (abort)
               st_d = HOLDOFF;
            else if (fill_done)
               st_d = SEARCH;
         end
         SEARCH: begin
            if (abort)
               st_d = HOLDOFF;
            else if (det_ev)
               st_d = LOCKED;
            else if (to_ev)
               st_d = HOLDOFF;
         end
         LOCKED: begin
            if (abort)
               st_d = HOLDOFF;
         end
         HOLDOFF: begin
            if (hold_done)
               st_d = (AUTO_RESTART != 0) ? FILL : IDLE;
         end
         default: st_d = IDLE;
      endcase
   end

   // next registered outputs
   always_comb begin
      dly_d  = (st_d == FILL) || (st_d == SEARCH) ||
               (st_d == LOCKED);
      srch_d = (st_d == SEARCH);
      det_d  = det_ev && !abort;
      to_d   = to_ev && !abort;
      idx_d  = detect_idx;
      if (start_ok)
         idx_d = '0;
      if (det_d)
         idx_d = sample_cnt;
   end

   assign state = st;

endmodule

// File: tb/tb_sync_short_ctrl.sv
// Scoreboard bench for sync_short_ctrl with a run-length reference model.
// Two instances: AUTO_RESTART=0 (main) and AUTO_RESTART=1.
module tb_sync_short_ctrl;

   logic        clk = 1'b0;
   logic        s_rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        strobe = 1'b0;
   logic [31:0] corr = '0;
   logic [31:0] pwr = '0;

   logic        dly0, srch0, det0, to0;
   logic [15:0] idx0;
   logic [2:0]  st0;
   logic        dly1, srch1, det1, to1;
   logic [15:0] idx1;
   logic [2:0]  st1;

   int n_pass = 0;
   int n_tot  = 0;

   int          sbq[$];
   logic [31:0] cq[$];
   logic [31:0] pq[$];

   always #5 clk = ~clk;

   sync_short_ctrl #(
      .DELAY_LEN(16), .MAG_W(32), .THRESH(6),
      .PLATEAU_MIN(48), .PWR_MIN(100),
      .TIMEOUT_SAMPLES(4000), .HOLDOFF_CYC(4),
      .AUTO_RESTART(0)
   ) u0 (
      .CLK(clk), .s_RST(s_rst), .start(start),
      .abort(abort), .sample_strobe(strobe),
      .corr_mag(corr), .pwr(pwr),
      .dly_enable(dly0), .search_active(srch0),
      .detect(det0), .detect_idx(idx0),
      .timeout(to0), .state(st0)
   );

   sync_short_ctrl #(
      .DELAY_LEN(16), .MAG_W(32), .THRESH(6),
      .PLATEAU_MIN(48), .PWR_MIN(100),
      .TIMEOUT_SAMPLES(4000), .HOLDOFF_CYC(4),
      .AUTO_RESTART(1)
   ) u1 (
      .CLK(clk), .s_RST(s_rst), .start(start),
      .abort(abort), .sample_strobe(strobe),
      .corr_mag(corr), .pwr(pwr),
      .dly_enable(dly1), .search_active(srch1),
      .detect(det1), .detect_idx(idx1),
      .timeout(to1), .state(st1)
   );

   task automatic chk(string nm, longint got, longint exp);
      n_tot++;
      if (got == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
   endtask

   // monitor: every detect/timeout pulse of u0 must match the queue head
   always @(negedge clk) begin
      int exp;
      int got;
      if (!s_rst && (det0 || to0)) begin
         exp = (sbq.size() != 0) ? sbq.pop_front() : -2;
         got = det0 ? int'(idx0) : -1;
         chk("event", got, exp);
         chk("pulse_excl", det0 & to0, 0);
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 2)) step();
   endtask

   task automatic strb(logic [31:0] c, logic [31:0] p, bit ab);
      strobe = 1'b1;
      corr   = c;
      pwr    = p;
      abort  = ab;
      step();
      strobe = 1'b0;
      abort  = 1'b0;
      corr   = $urandom;
      pwr    = $urandom;
   endtask

   task automatic do_reset();
      s_rst = 1'b1;
      step();
      step();
      s_rst = 1'b0;
   endtask

   // spec rule as plain arithmetic: first index of a 48-hit run,
   // -1 for timeout at strobe 4000, -3 if neither
   function automatic int model_evt();
      int run = 0;
      for (int i = 0; i < cq.size(); i++) begin
         longint unsigned l = longint'(cq[i]) * 8;
         longint unsigned r = longint'(pq[i]) * 6;
         if (pq[i] >= 100 && l >= r)
            run++;
         else
            run = 0;
         if (run == 48)
            return i;
         if (i + 1 == 4000)
            return -1;
      end
      return -3;
   endfunction

   task automatic begin_search(string nm, bit with_abort);
      start = 1'b1;
      abort = with_abort;
      step();
      start = 1'b0;
      abort = 1'b0;
      chk({nm, "_dly_start"}, dly0, 1);
      for (int i = 0; i < 16; i++) begin
         strb(32'd800, 32'd1000, 1'b0);
         if (i == 14)
            chk({nm, "_srch_pre"}, srch0, 0);
         if (i == 15) begin
            chk({nm, "_srch_fill"}, srch0, 1);
            chk({nm, "_det_fill"}, det0, 0);
         end
         if (i < 15)
            gap();
      end
   endtask

   task automatic run_search(int n, bit abort_last);
      for (int i = 0; i < n; i++) begin
         strb(cq[i], pq[i], abort_last && (i == n - 1));
         if (i < n - 1)
            gap();
      end
   endtask

   // first sample is the cycle already in HOLDOFF; abort here is ignored
   task automatic holdoff_chk(string nm);
      for (int k = 0; k < 4; k++) begin
         chk({nm, "_ho_st"}, st0, 4);
         chk({nm, "_ho_dly"}, dly0, 0);
         abort = 1'($urandom_range(0, 1));
         step();
      end
      abort = 1'b0;
      chk({nm, "_ho_end"}, st0, 0);
      chk({nm, "_pending"}, sbq.size(), 0);
   endtask

   task automatic scenario(string nm);
      int e;
      e = model_evt();
      if (e >= 0) begin
         sbq.push_back(e);
         run_search(e + 1, 1'b0);
         chk({nm, "_locked"}, st0, 3);
         chk({nm, "_lk_dly"}, dly0, 1);
         start = 1'b1;
         step();
         start = 1'b0;
         chk({nm, "_lk_start"}, st0, 3);
         abort = 1'b1;
         step();
         abort = 1'b0;
         holdoff_chk(nm);
      end else begin
         sbq.push_back(-1);
         run_search(4000, 1'b0);
         holdoff_chk(nm);
      end
   endtask

   task automatic fill_hits(int n);
      for (int i = 0; i < n; i++) begin
         cq.push_back(32'd800);
         pq.push_back(32'd1000);
      end
   endtask

   task automatic gen_random();
      longint p;
      longint c;
      int r;
      cq.delete();
      pq.delete();
      for (int i = 0; i < 4000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 3) begin
            p = $urandom_range(100, 5000);
            c = (p * 6 - 1) / 8;
         end else if (r < 5) begin
            p = $urandom_range(0, 99);
            c = $urandom;
         end else if (r < 8) begin
            c = $urandom_range(25, 1000);
            p = c * 4;
            c = c * 3;
         end else if (r < 10) begin
            p = $urandom | 32'h8000_0000;
            c = $urandom | 32'h8000_0000;
         end else begin
            p = $urandom_range(100, 100000);
            c = (p * 6 + 7) / 8 + $urandom_range(0, 10);
         end
         cq.push_back(32'(c));
         pq.push_back(32'(p));
      end
   endtask

   initial begin
      do_reset();
      chk("rst_state", st0, 0);
      chk("rst_dly", dly0, 0);
      chk("rst_srch", srch0, 0);
      chk("rst_det", det0, 0);
      chk("rst_to", to0, 0);
      chk("rst_idx", idx0, 0);

      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("idle_abort", st0, 0);

      // detection: 48 clean hits
      begin_search("det", 1'b1);
      cq.delete(); pq.delete();
      fill_hits(48);
      scenario("det");

      // plateau broken by one miss
      begin_search("brk", 1'b0);
      cq.delete(); pq.delete();
      fill_hits(47);
      cq.push_back(32'd700);
      pq.push_back(32'd1000);
      fill_hits(48);
      scenario("brk");

      // abort together with the 48th hit strobe
      begin_search("abt", 1'b0);
      cq.delete(); pq.delete();
      fill_hits(48);
      run_search(48, 1'b1);
      holdoff_chk("abt");

      // power floor -> timeout
      begin_search("flr", 1'b0);
      cq.delete(); pq.delete();
      for (int i = 0; i < 4000; i++) begin
         cq.push_back(32'd1000);
         pq.push_back(32'd50);
      end
      scenario("flr");

      // randomized searches including exact-threshold and wide values
      for (int it = 0; it < 2; it++) begin
         gen_random();
         begin_search("rnd", 1'b0);
         scenario("rnd");
      end

      // AUTO_RESTART instance: timeout, holdoff, refill, reset mid-FILL
      do_reset();
      begin_search("ar", 1'b0);
      sbq.push_back(-1);
      for (int i = 0; i < 4000; i++) begin
         strb(32'd1000, 32'd50, 1'b0);
         if (i < 3999)
            gap();
      end
      chk("ar_timeout", to1, 1);
      for (int k = 0; k < 4; k++) begin
         chk("ar_ho_dly", dly1, 0);
         chk("ar_ho_st", st1, 4);
         step();
      end
      chk("ar_refill_st", st1, 1);
      chk("ar_refill_dly", dly1, 1);
      for (int i = 0; i < 15; i++) begin
         strb(32'd800, 32'd1000, 1'b0);
         gap();
      end
      chk("ar_fill_cleared", st1, 1);
      s_rst = 1'b1;
      step();
      chk("ar_rst_st", st1, 0);
      chk("ar_rst_outs", {dly1, srch1, det1, to1, idx1}, 0);
      s_rst = 1'b0;
      step();
      chk("ar_pending", sbq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/sync_short_ctrl.md
Name: sync_short_ctrl

Overview:
Sequencing controller for the short-preamble synchronizer delay lines and the plateau search.
- Gates the delay-line enable; enable low clears the delay lines.
- Waits for the delay lines to fill, then compares the autocorrelation magnitude against scaled power on every sample strobe.
- Declares short-preamble detection after a sustained plateau, or times out and recycles.
- Sits between the packet-start logic and the delay/correlation datapath in the sync-short chain.

Parameters:
DELAY_LEN, 16, delay-line depth in samples; fill wait length
MAG_W, 32, width of corr_mag and pwr (unsigned)
THRESH, 6, plateau threshold in Q3 (6 = 0.75)
PLATEAU_MIN, 48, consecutive hit strobes required for detection
PWR_MIN, 100, power floor; pwr below this counts as a miss
TIMEOUT_SAMPLES, 4000, max SEARCH strobes before timeout
HOLDOFF_CYC, 4, clock cycles dly_enable held low after timeout/abort
AUTO_RESTART, 0, 1 = go straight from HOLDOFF to FILL

Ports:
CLK  in  1  clock
s_RST  in  1  reset s_RST, synchronous, active-high; clock CLK
start  in  1  begin search; honoured only in IDLE
abort  in  1  cancel from any non-IDLE state
sample_strobe  in  1  one per valid input sample
corr_mag  in  MAG_W  autocorrelation magnitude, aligned with sample_strobe
pwr  in  MAG_W  window power, aligned with sample_strobe
dly_enable  out  1  drives delay-line enable (low = cleared)
search_active  out  1  high in SEARCH
detect  out  1  one-cycle detection pulse
detect_idx  out  16  sample_cnt value at detection strobe, held until next start
timeout  out  1  one-cycle timeout pulse
state  out  3  current state for debug

Behaviour:
- Reset: state=IDLE; dly_enable=0, search_active=0, detect=0, timeout=0, detect_idx=0; all counters 0.
- All outputs are registered. Every transition takes effect the cycle after the qualifying input.
- IDLE: dly_enable=0.
  - start=1 -> FILL.
  - Clear fill_cnt, sample_cnt and plateau_cnt.
- FILL: dly_enable=1.
  - fill_cnt increments per sample_strobe.
  - On the strobe that makes fill_cnt==DELAY_LEN -> SEARCH.
  - That strobe's metric is not evaluated.
- SEARCH: dly_enable=1, search_active=1.
  - Per strobe: hit = (pwr>=PWR_MIN) && ({corr_mag,3'b0} >= pwr*THRESH).
  - Compute the comparison at full width (MAG_W+8 bits); no truncation.
  - hit -> plateau_cnt+1; miss -> plateau_cnt=0.
  - sample_cnt increments per strobe and saturates at 16'hFFFF.
  - If plateau_cnt+1==PLATEAU_MIN on a hit strobe: go to LOCKED, detect=1 for one cycle, detect_idx=sample_cnt of that strobe.
  - Else, on the strobe where sample_cnt+1==TIMEOUT_SAMPLES: go to HOLDOFF, timeout=1 for one cycle.
- LOCKED: dly_enable=1 (downstream fine sync uses the delay lines).
  - Stays until abort; start is ignored.
- HOLDOFF: dly_enable=0 for exactly HOLDOFF_CYC cycles (hold_cnt).
  - Then go to IDLE, or to FILL if AUTO_RESTART=1 (counters cleared).
- No sample_strobe: counters hold. Idle cycles between strobes never reset the plateau.
- Priority within one cycle: s_RST > abort > detect > timeout > fill completion.
  - abort in FILL/SEARCH/LOCKED -> HOLDOFF with no detect or timeout pulse.
  - abort in IDLE or HOLDOFF is ignored.
- start arriving together with abort is ignored unless in IDLE. In IDLE, start wins.
- s_RST mid-search: immediate return to IDLE next cycle, dly_enable=0.
- Pulses detect and timeout never assert in the same cycle.

Decomposition:
- Package sync_short_pkg:
  - state enum: IDLE=0, FILL=1, SEARCH=2, LOCKED=3, HOLDOFF=4
  - Q3 shift constant (3)
  - default THRESH/PLATEAU_MIN values shared with the datapath
- Sub-module sync_plateau_cnt: comparator, power floor, and plateau counter.
  - Inputs: strobe, clear, corr_mag, pwr.
  - Outputs: hit, plateau_reached.
- FSM and counters stay in the top module.

Test Plan:
- Fill timing: s_RST, start, then 16 strobes with corr_mag=0 -> dly_enable=1 one cycle after start; search_active rises one cycle after the 16th strobe; no detect.
- Detection: SEARCH with pwr=1000 and corr_mag=800 for 48 strobes (800*8=6400 >= 6000) -> detect pulses once after the 48th strobe; detect_idx=47; dly_enable stays 1.
- Plateau break: 47 hits, 1 miss (corr_mag=700 -> 5600<6000), then 48 hits -> detect after strobe 96; detect_idx=95.
- Power floor: pwr=50 and corr_mag=1000 for 4000 strobes -> no detect; timeout pulses after strobe 4000; dly_enable low for exactly 4 cycles, then IDLE.
- Abort/priority: abort on the same cycle as the 48th hit strobe -> no detect pulse; HOLDOFF entered; dly_enable=0 for 4 cycles.
- AUTO_RESTART=1 with timeout -> after 4 holdoff cycles, FILL entered without start; counters cleared; s_RST mid-FILL -> IDLE next cycle with all outputs 0.
